// File: rtl/play_mode_ctrl.sv
// Play-mode controller: sequences song players (idle/play/pause/done), counts
// completed notes and arbitrates live keyboard vs. player notes to the tone generator.
module play_mode_ctrl #(
  parameter int unsigned SONG_LEN = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_play,
  input  logic        btn_stop,
  input  logic [1:0]  song_sel,
  input  logic        live_on,
  input  logic [3:0]  live_key,
  input  logic [3:0]  pl_key_on,
  input  logic [15:0] pl_key,
  output logic [3:0]  pl_rst,
  output logic        pl_ce,
  output logic        key_on,
  output logic [3:0]  key,
  output logic [1:0]  state,
  output logic [1:0]  active_song,
  output logic        song_done
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LEN = CNT_W'(SONG_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_n;
  logic [1:0]       song_q, song_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             edge_q, edge_n;
  logic             pl_ce_q, pl_ce_n;
  logic [3:0]       pl_rst_q, pl_rst_n;
  logic             key_on_q, key_on_n;
  logic [3:0]       key_q, key_n;
  logic             done_q, done_n;

  logic       cur_on;
  logic [3:0] cur_key;
  logic       fall;
  logic       hit_end;

  assign cur_on  = pl_key_on[song_q];
  assign cur_key = 4'(pl_key >> {song_q, 2'b00});
  assign fall    = pl_ce_q && edge_q && !cur_on;
  assign hit_end = fall && (cnt_q + CNT_W'(1) == LEN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      song_q   <= 2'd0;
      cnt_q    <= '0;
      edge_q   <= 1'b0;
      pl_ce_q  <= 1'b0;
      pl_rst_q <= 4'hF;
      key_on_q <= 1'b0;
      key_q    <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      song_q   <= song_n;
      cnt_q    <= cnt_n;
      edge_q   <= edge_n;
      pl_ce_q  <= pl_ce_n;
      pl_rst_q <= pl_rst_n;
      key_on_q <= key_on_n;
      key_q    <= key_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    song_n   = song_q;
    cnt_n    = cnt_q;
    edge_n   = edge_q;
    key_on_n = 1'b0;
    key_n    = key_q;

    // Note counting only while the player is actually clocked
    if (pl_ce_q) begin
      edge_n = cur_on;
      if (fall && cnt_q != LEN) cnt_n = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: if (btn_play && !btn_stop) begin
        state_n = PLAY;
        song_n  = song_sel;
        cnt_n   = '0;
        edge_n  = 1'b0;
      end
      PLAY: begin
        if (btn_stop)      state_n = IDLE;
        else if (hit_end)  state_n = DONE;
        else if (btn_play) state_n = PAUSE;
      end
      PAUSE: begin
        if (btn_stop)      state_n = IDLE;
        else if (btn_play) state_n = PLAY;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    pl_ce_n  = (state_n == PLAY) && !live_on;
    pl_rst_n = (state_n == PLAY || state_n == PAUSE) ? ~(4'b0001 << song_n) : 4'hF;
    done_n   = (state_n == DONE);

    // Live keyboard always wins over the song player
    if (live_on) begin
      key_on_n = 1'b1;
      key_n    = live_key;
    end else if (state_q == PLAY) begin
      key_on_n = cur_on;
      key_n    = cur_key;
    end
  end

  assign state       = state_q;
  assign active_song = song_q;
  assign pl_rst      = pl_rst_q;
  assign pl_ce       = pl_ce_q;
  assign key_on      = key_on_q;
  assign key         = key_q;
  assign song_done   = done_q;

endmodule

// File: doc/play_mode_ctrl.md
PLAY_MODE_CTRL -- requirements
Module: play_mode_ctrl

Interface
REQ-001 Parameter: SONG_LEN, default 24, number of completed notes after which a song is finished (1..255).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: btn_play  input  1  single-cycle pulse; start / pause / resume.
REQ-005 Port: btn_stop  input  1  single-cycle pulse; abort playback.
REQ-006 Port: song_sel  input  2  song player index to start; sampled only in IDLE.
REQ-007 Port: live_on  input  1  live keyboard note active.
REQ-008 Port: live_key  input  4  live keyboard note index.
REQ-009 Port: pl_key_on  input  4  key_on of song players 0..3, bit n = player n.
REQ-010 Port: pl_key  input  16  key of song players, player n on bits [4n+3:4n].
REQ-011 Port: pl_rst  output  4  per-player reset, bit n holds player n in reset.
REQ-012 Port: pl_ce  output  1  clock enable for the active player.
REQ-013 Port: key_on  output  1  arbitrated note-active to tone generator.
REQ-014 Port: key  output  4  arbitrated note index to tone generator.
REQ-015 Port: state  output  2  FSM state: 0 IDLE, 1 PLAY, 2 PAUSE, 3 DONE.
REQ-016 Port: active_song  output  2  index of the latched player.
REQ-017 Port: song_done  output  1  one-cycle pulse on song completion.

Function
REQ-018 FSM transitions SHALL be: IDLE+btn_play -> PLAY (latch song_sel into active_song, clear note_cnt and edge register); PLAY+btn_play -> PAUSE; PAUSE+btn_play -> PLAY; PLAY/PAUSE+btn_stop -> IDLE; PLAY with note_cnt reaching SONG_LEN -> DONE; DONE -> IDLE unconditionally next cycle.
REQ-019 btn_play and btn_stop asserted in the same cycle SHALL be treated as btn_stop only; btn_stop in IDLE or DONE SHALL have no effect; btn_play in DONE SHALL be ignored.
REQ-020 song_sel changes outside IDLE SHALL not affect active_song.
REQ-021 pl_rst SHALL be 4'hF in IDLE and DONE, and in PLAY/PAUSE all ones except bit active_song, which is 0 (registered, same cycle as state).
REQ-022 pl_ce SHALL be 1 only when state==PLAY and live_on==0, else 0; registered alongside state.
REQ-023 An 8-bit note_cnt SHALL increment on each cycle with pl_ce==1 where pl_key_on[active_song] is 0 and its value registered the previous cycle was 1 (falling edge); edge register updates only when pl_ce==1.
REQ-024 When the increment makes note_cnt equal SONG_LEN, the next state SHALL be DONE and song_done SHALL pulse high for exactly the DONE cycle; a btn_stop in that same cycle wins (IDLE, no song_done).
REQ-025 key_on/key SHALL be registered (1-cycle latency) with priority: live_on==1 -> key_on=1, key=live_key; else state==PLAY -> key_on=pl_key_on[active_song], key=pl_key[4*active_song+:4]; else key_on=0, key holds its previous value.
REQ-026 Live override during PLAY SHALL freeze the player (pl_ce=0) without changing state; playback resumes the cycle after live_on falls.
REQ-027 note_cnt SHALL not wrap; it saturates at SONG_LEN since DONE is entered.

Reset
REQ-028 On rst: state=IDLE, active_song=0, note_cnt=0, edge register=0, pl_rst=4'hF, pl_ce=0, key_on=0, key=0, song_done=0; reset mid-playback SHALL abort immediately with these values, independent of clk.

Verification
REQ-029 Start: song_sel=2, btn_play pulse in IDLE -> next cycle state=1, active_song=2, pl_rst=4'b1011, pl_ce=1.
REQ-030 Completion (SONG_LEN=3): three pl_key_on[2] 1->0 falling edges in PLAY -> after third, state=3 and song_done=1 for one cycle, then state=0, pl_rst=4'hF.
REQ-031 Pause/resume: btn_play in PLAY -> state=2, pl_ce=0, key_on=0; falling edges ignored; btn_play again -> state=1, pl_ce=1.
REQ-032 Live override: PLAY, live_on=1, live_key=4'd7 -> next cycle key_on=1, key=7, pl_ce=0, state=1; live_on=0 -> key follows player, pl_ce=1.
REQ-033 Simultaneous btn_play+btn_stop in PLAY -> state=0, no PAUSE, song_done=0.
REQ-034 rst asserted mid-PLAY between clock edges -> outputs immediately at REQ-028 values; song_sel change during PLAY leaves active_song unchanged.
